seq_shift_add_multiplier: RTL and testbench

//  Unsigned WIDTH x WIDTH multiplier built on a single WIDTH-bit ripple adder, reused once per cycle.

---
 rtl/arith_pkg.sv | 18 +
 rtl/nbit_ripple_adder.sv | 25 ++
 rtl/seq_shift_add_multiplier.sv | 110 +++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic types for the sequential multiplier slice.
// State encoding and counter sizing helpers.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int DEF_WIDTH = 4;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/nbit_ripple_adder.sv
// Combinational WIDTH-bit ripple-carry adder.
// At WIDTH=4 this is the team's 4-bit ripple adder.
module nbit_ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  // carry ripples LSB to MSB through full-adder cells
  always_comb begin
    logic cy;
    cy  = carry_in;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = x[i] ^ y[i] ^ cy;
      cy     = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
    end
    carry_out = cy;
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned WIDTH x WIDTH shift-add multiplier reusing one ripple adder.
// One partial-product step per cycle, start/done handshake.
module seq_shift_add_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t state_q;
  mult_state_t state_d;

  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   mq_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_mq;
  logic             last_step;

  assign addend = mq_q[0] ? mcand_q : '0;

  nbit_ripple_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .x         (acc_q),
    .y         (addend),
    .carry_in  (1'b0),
    .sum       (sum),
    .carry_out (carry)
  );

  // carry becomes the new acc MSB; sum LSB shifts into mq
  assign step_acc  = {carry, sum[WIDTH-1:1]};
  assign step_mq   = {sum[0], mq_q[WIDTH-1:1]};
  assign last_step = (cnt_q == LAST);

  // next-state decode: IDLE -> RUN -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register; reset wins over a same-cycle start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // operand capture, shift-add step and product load
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q   <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q <= a;
            mq_q    <= b;
            acc_q   <= '0;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          acc_q <= step_acc;
          mq_q  <= step_mq;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            product_q <= {step_acc, step_mq};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier (WIDTH=4).
// Scoreboard queue filled on acceptance, drained on done.
module tb_seq_shift_add_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_chk  = 0;
  int n_pass = 0;

  logic [2*W-1:0] exp_q[$];
  int             mdl_left = 0;
  logic [2*W-1:0] held = '0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  function automatic logic [2*W-1:0] mul(input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [2*W-1:0] xx;
    logic [2*W-1:0] yy;
    xx = {{W{1'b0}}, x};
    yy = {{W{1'b0}}, y};
    return xx * yy;
  endfunction

  // reference timing model: accept only when idle, busy for W+1 cycles
  always @(posedge clk) begin
    if (rst) begin
      mdl_left = 0;
      held     = '0;
      exp_q.delete();
    end else if (mdl_left == 0) begin
      if (start) begin
        exp_q.push_back(mul(a, b));
        mdl_left = W + 1;
      end
    end else begin
      mdl_left = mdl_left - 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_chk++;
      if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
      else n_pass++;
      n_chk++;
      if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done);
      else n_pass++;
      n_chk++;
      if (product !== '0) $display("FAIL reset_product got %0d want 0", product);
      else n_pass++;
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b0)
        $display("FAIL idle_no_done got busy=%b done=%b want 0/0", busy, done);
      else n_pass++;
    end
  endtask

  task automatic test_mult(input logic [W-1:0] x,
                           input logic [W-1:0] y,
                           input string nm);
    bit             seen;
    logic [2*W-1:0] exp;
    seen  = 1'b0;
    a     = x;
    b     = y;
    start = 1'b1;
    for (int k = 1; k <= 12 && !seen; k++) begin
      cyc();
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      n_chk++;
      if (busy !== (mdl_left != 0))
        $display("FAIL %s busy k=%0d got %b want %b", nm, k, busy, mdl_left != 0);
      else n_pass++;
      n_chk++;
      if (done !== (mdl_left == 1))
        $display("FAIL %s done k=%0d got %b want %b", nm, k, done, mdl_left == 1);
      else n_pass++;
      if (done === 1'b1) begin
        seen = 1'b1;
        n_chk++;
        if (k != W + 1) $display("FAIL %s latency got %0d want %0d", nm, k, W + 1);
        else n_pass++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_chk++;
        if (product !== exp)
          $display("FAIL %s product %0d*%0d got %0d want %0d", nm, x, y, product, exp);
        else n_pass++;
        held = exp;
      end else begin
        n_chk++;
        if (product !== held)
          $display("FAIL %s hold k=%0d got %0d want %0d", nm, k, product, held);
        else n_pass++;
      end
    end
    if (!seen) begin
      n_chk++;
      $display("FAIL %s timeout got no done want done", nm);
    end
    cyc();
    n_chk++;
    if (busy !== 1'b0) $display("FAIL %s back_idle got busy=%b want 0", nm, busy);
    else n_pass++;
  endtask

  task automatic test_corners();
    test_mult(4'd15, 4'd15, "max");
    test_mult(4'd0,  4'd9,  "zero_a");
    test_mult(4'd9,  4'd0,  "zero_b");
    test_mult(4'd1,  4'd15, "one");
  endtask

  task automatic test_back_to_back();
    int             prev;
    int             ndone;
    logic [2*W-1:0] exp;
    prev  = 0;
    ndone = 0;
    for (int k = 1; k <= 44; k++) begin
      start = (k <= 36);
      a     = W'($urandom);
      b     = W'($urandom);
      cyc();
      n_chk++;
      if (busy !== (mdl_left != 0))
        $display("FAIL b2b busy k=%0d got %b want %b", k, busy, mdl_left != 0);
      else n_pass++;
      n_chk++;
      if (done !== (mdl_left == 1))
        $display("FAIL b2b done k=%0d got %b want %b", k, done, mdl_left == 1);
      else n_pass++;
      if (done === 1'b1) begin
        ndone++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_chk++;
        if (product !== exp)
          $display("FAIL b2b product k=%0d got %0d want %0d", k, product, exp);
        else n_pass++;
        held = exp;
        if (prev != 0) begin
          n_chk++;
          if (k - prev != W + 2)
            $display("FAIL b2b period got %0d want %0d", k - prev, W + 2);
          else n_pass++;
        end
        prev = k;
      end else begin
        n_chk++;
        if (product !== held)
          $display("FAIL b2b hold k=%0d got %0d want %0d", k, product, held);
        else n_pass++;
      end
    end
    start = 1'b0;
    n_chk++;
    if (ndone != 6) $display("FAIL b2b count got %0d want 6", ndone);
    else n_pass++;
  endtask

  task automatic test_abort();
    a     = 4'd7;
    b     = 4'd6;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    rst   = 1'b1;
    start = 1'b1;
    cyc();
    n_chk++;
    if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy);
    else n_pass++;
    n_chk++;
    if (done !== 1'b0) $display("FAIL abort_done got %b want 0", done);
    else n_pass++;
    n_chk++;
    if (product !== '0) $display("FAIL abort_product got %0d want 0", product);
    else n_pass++;
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== '0)
        $display("FAIL abort_quiet got busy=%b done=%b product=%0d want 0/0/0",
                 busy, done, product);
      else n_pass++;
    end
    test_mult(4'd7, 4'd6, "abort_retry");
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      test_mult(W'($urandom), W'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_mult(4'd13, 4'd11, "basic");
    test_corners();
    test_back_to_back();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
